// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// Optional feature macro: UART_RX_PARITY_EN (adds the even-parity PARITY state).
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DATA_W               = 8;
    localparam int CNT_W                = 16;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } uart_state_t;
`endif

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for uart_rx. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate counter.
// A push while full is accepted only when a pop happens on the same edge.
// A pop while empty is ignored. The head is forced to zero while empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage write; a full-FIFO push+pop reuses the slot being freed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer update, wrapping modulo FIFO_DEPTH with the extra wrap bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, receive FIFO,
// sticky error flags and a registered level interrupt.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit and PAR_ERR output).
// STATE exposes the receive FSM state for observation.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RXD,
    input  logic              RD_EN,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_VALID,
    input  logic              INT_EN,
    input  logic              CLR_ERR,
    output logic              OVERRUN,
    output logic              FRAME_ERR,
`ifdef UART_RX_PARITY_EN
    output logic              PAR_ERR,
`endif
    output logic              UART_INT,
    output uart_state_t       STATE
);

    localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);

    logic              rxd_meta;
    logic              rxd_sync;
    logic              rxd_prev;
    logic              fall;

    uart_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              brk_q, brk_d;
    logic              tick;
    logic              push;
    logic              frame_set;
    logic              overrun_set;
    logic              fifo_full;
    logic              fifo_empty;
    logic              err_any;
`ifdef UART_RX_PARITY_EN
    logic              par_bad_q, par_bad_d;
    logic              par_set;
`endif

    // RXD synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign fall = rxd_prev & ~rxd_sync;
    // A state with counter value N acts after exactly N cycles.
    assign tick = (cnt_q == CNT_W'(1));

    // FSM and datapath registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            brk_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            brk_q     <= brk_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Next-state logic: half-bit delay to the start-bit centre, then one
    // bit period between samples. A low stop bit parks in STOP (brk_q)
    // until the line returns high.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        brk_d     = brk_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        par_set   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    cnt_d   = HALF_CNT;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (!rxd_sync) begin
                        state_d = ST_DATA;
                        cnt_d   = BIT_CNT;
                        bit_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d = {rxd_sync, shreg_q[DATA_W-1:1]};
                    cnt_d   = BIT_CNT;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    par_set   = (rxd_sync != ^shreg_q);
                    par_bad_d = par_set;
                    cnt_d     = BIT_CNT;
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (brk_q) begin
                    if (rxd_sync) begin
                        brk_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (tick) begin
                    if (rxd_sync) begin
`ifdef UART_RX_PARITY_EN
                        push = ~par_bad_q;
`else
                        push = 1'b1;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        brk_d     = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Consumer handshake: RD_VALID means RD_DATA holds the head byte; a cycle
    // with RD_EN=1 and RD_VALID=1 pops it on that edge; RD_EN alone is ignored.
    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (DATA_W)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RESET),
        .push      (push),
        .push_data (shreg_q),
        .pop       (RD_EN),
        .pop_data  (RD_DATA),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign RD_VALID    = ~fifo_empty;
    assign STATE       = state_q;
    assign overrun_set = push & fifo_full & ~RD_EN;

`ifdef UART_RX_PARITY_EN
    assign err_any = OVERRUN | FRAME_ERR | PAR_ERR;
`else
    assign err_any = OVERRUN | FRAME_ERR;
`endif

    // Sticky error flags (set beats clear) and the registered interrupt.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            OVERRUN   <= 1'b0;
            FRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            PAR_ERR   <= 1'b0;
`endif
            UART_INT  <= 1'b0;
        end else begin
            if (overrun_set)  OVERRUN <= 1'b1;
            else if (CLR_ERR) OVERRUN <= 1'b0;
            if (frame_set)    FRAME_ERR <= 1'b1;
            else if (CLR_ERR) FRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (par_set)      PAR_ERR <= 1'b1;
            else if (CLR_ERR) PAR_ERR <= 1'b0;
`endif
            UART_INT <= INT_EN & (RD_VALID | err_any);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Honours UART_RX_PARITY_EN when defined (frames then carry an even parity bit).
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        rxd     = 1'b1;
    logic        rd_en   = 1'b0;
    logic        int_en  = 1'b0;
    logic        clr_err = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        overrun;
    logic        frame_err;
    logic        uart_int;
    uart_state_t state;
`ifdef UART_RX_PARITY_EN
    logic        par_err;
    logic        par_flip = 1'b0;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_q[$];
    int          stop_lat = 0;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .RXD       (rxd),
        .RD_EN     (rd_en),
        .RD_DATA   (rd_data),
        .RD_VALID  (rd_valid),
        .INT_EN    (int_en),
        .CLR_ERR   (clr_err),
        .OVERRUN   (overrun),
        .FRAME_ERR (frame_err),
`ifdef UART_RX_PARITY_EN
        .PAR_ERR   (par_err),
`endif
        .UART_INT  (uart_int),
        .STATE     (state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        cycles(CPB);
    endtask

    // Drives start, data and optional parity; leaves RXD at the stop value.
    task automatic send_frame(input logic [7:0] d, input logic stop_val);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        rxd = stop_val;
    endtask

    task automatic send_ok(input logic [7:0] d);
        exp_q.push_back(d);
        send_frame(d, 1'b1);
        cycles(CPB);
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // Scoreboard pop: wait (bounded) for data, compare head, pop it.
    task automatic pop_check(input string tag);
        logic [7:0] exp;
        bit         got;
        got = 1'b0;
        for (int i = 0; i < 4 * CPB && !got; i++) begin
            if (rd_valid) got = 1'b1;
            else @(negedge clk);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, rd_data}, {24'd0, exp});
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin : main
        uart_state_t prev;
        logic        valid_before;
        int          lat;

        // Reset state.
        int_en = 1'b1;
        cycles(3);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_data", {24'd0, rd_data}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_frame", {31'd0, frame_err}, 32'd0);
        check("rst_int", {31'd0, uart_int}, 32'd0);
        check("rst_state", {29'd0, state}, {29'd0, ST_IDLE});
        rst_n = 1'b1;
        cycles(4);

        // 0xA5: data visible the cycle after the stop sample, interrupt one later.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        prev = state;
        valid_before = 1'b1;
        for (int i = 1; i <= 2 * CPB && stop_lat == 0; i++) begin
            @(negedge clk);
            if (prev == ST_STOP && state != ST_STOP) stop_lat = i;
            else valid_before = rd_valid;
            prev = state;
        end
        check("a5_stop_seen", {31'd0, stop_lat > 0}, 32'd1);
        check("a5_valid_before", {31'd0, valid_before}, 32'd0);
        check("a5_valid_after", {31'd0, rd_valid}, 32'd1);
        check("a5_int_same", {31'd0, uart_int}, 32'd0);
        @(negedge clk);
        check("a5_int_next", {31'd0, uart_int}, 32'd1);
        pop_check("a5");
        check("a5_empty", {31'd0, rd_valid}, 32'd0);
        cycles(CPB);

        // Short glitch must be rejected in START.
        rxd = 1'b0;
        cycles(5);
        rxd = 1'b1;
        cycles(2 * CPB);
        check("glitch_state", {29'd0, state}, {29'd0, ST_IDLE});
        cycles(12 * CPB);
        check("glitch_valid", {31'd0, rd_valid}, 32'd0);
        check("glitch_frame", {31'd0, frame_err}, 32'd0);
        check("glitch_overrun", {31'd0, overrun}, 32'd0);

        // 0x3C with stop bit low: framing error, nothing stored.
        send_frame(8'h3C, 1'b0);
        cycles(CPB);
        check("fe_set", {31'd0, frame_err}, 32'd1);
        check("fe_empty", {31'd0, rd_valid}, 32'd0);
        check("fe_wait", {29'd0, state}, {29'd0, ST_STOP});
        check("fe_int", {31'd0, uart_int}, 32'd1);
        rxd = 1'b1;
        cycles(4);
        check("fe_idle", {29'd0, state}, {29'd0, ST_IDLE});
        clear_errors();
        check("fe_clr", {31'd0, frame_err}, 32'd0);
        cycles(CPB);

        // Five bytes into a four-entry FIFO: the fifth is dropped.
        for (int b = 1; b <= 5; b++) begin
            if (b <= 4) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1);
            cycles(CPB);
            if (b == 4) check("ov_before", {31'd0, overrun}, 32'd0);
        end
        check("ov_set", {31'd0, overrun}, 32'd1);
        for (int b = 1; b <= 4; b++) pop_check("ov_pop");
        check("ov_drain", {31'd0, rd_valid}, 32'd0);
        check("ov_sticky", {31'd0, overrun}, 32'd1);
        clear_errors();
        check("ov_clr", {31'd0, overrun}, 32'd0);

        // Five bytes with a pop on the same edge as the fifth push: no overrun.
        for (int b = 0; b < 4; b++) send_ok(8'h21 + 8'(b));
        exp_q.push_back(8'h25);
        send_frame(8'h25, 1'b1);
        lat = (stop_lat > 1) ? stop_lat : 11;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (i == lat - 1) begin
                check("pp_head", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
                rd_en = 1'b1;
            end
            if (i == lat) rd_en = 1'b0;
        end
        cycles(CPB - lat);
        check("pp_no_overrun", {31'd0, overrun}, 32'd0);
        for (int b = 0; b < 4; b++) pop_check("pp_pop");
        check("pp_drain", {31'd0, rd_valid}, 32'd0);

        // Reset in the middle of 0xFF (after data bit 3) with a byte queued.
        send_ok(8'h5A);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        cycles(2);
        check("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
        check("mid_rst_data", {24'd0, rd_data}, 32'd0);
        check("mid_rst_int", {31'd0, uart_int}, 32'd0);
        check("mid_rst_state", {29'd0, state}, {29'd0, ST_IDLE});
        rst_n = 1'b1;
        for (int i = 4; i < 8; i++) drive_bit(1'b1);
        cycles(2 * CPB);
        check("mid_rst_quiet", {31'd0, rd_valid}, 32'd0);
        send_ok(8'h12);
        pop_check("after_rst");
        check("after_rst_drain", {31'd0, rd_valid}, 32'd0);

`ifdef UART_RX_PARITY_EN
        // 0x07 with parity bit 0 (wrong), then with parity bit 1 (correct).
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        cycles(CPB);
        check("par_set", {31'd0, par_err}, 32'd1);
        check("par_drop", {31'd0, rd_valid}, 32'd0);
        par_flip = 1'b0;
        send_ok(8'h07);
        pop_check("par_ok");
        clear_errors();
        check("par_clr", {31'd0, par_err}, 32'd0);
`endif

        check("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning CLK cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries; power of two, 2..64.
REQ-003 The block SHALL have port CLK  input  1  the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port RXD  input  1  asynchronous serial line; idles high.
REQ-006 The block SHALL have port RD_EN  input  1  pop request from the CSR/load path.
REQ-007 The block SHALL have port RD_DATA  output  8  head-of-FIFO byte; valid only while RD_VALID=1.
REQ-008 The block SHALL have port RD_VALID  output  1  FIFO not empty.
REQ-009 The block SHALL have port INT_EN  input  1  interrupt enable.
REQ-010 The block SHALL have port CLR_ERR  input  1  clears OVERRUN and FRAME_ERR.
REQ-011 The block SHALL have port OVERRUN  output  1  sticky: byte dropped because the FIFO was full.
REQ-012 The block SHALL have port FRAME_ERR  output  1  sticky: stop bit sampled low.
REQ-013 The block SHALL have port UART_INT  output  1  level interrupt to the core writeback stage.

Function
REQ-014 RXD SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-015 The receive FSM SHALL have states IDLE, START, DATA, STOP, plus PARITY when UART_RX_PARITY_EN is defined.
REQ-016 IDLE->START SHALL occur on a synchronized high-to-low transition; the bit counter then loads CLKS_PER_BIT/2 (integer division).
REQ-017 In START at counter expiry, RXD=0 SHALL go to DATA; RXD=1 SHALL return to IDLE (glitch reject, no flags set).
REQ-018 DATA SHALL sample 8 bits LSB-first, each exactly CLKS_PER_BIT cycles after the previous sample.
REQ-019 In STOP at mid-bit, RXD=1 SHALL push the byte; RXD=0 SHALL discard it, set FRAME_ERR, and go to IDLE only after RXD returns high.
REQ-020 A push SHALL make the byte visible at RD_DATA, with RD_VALID=1, in the cycle after the stop-bit sample.
REQ-021 RD_EN while RD_VALID=1 SHALL pop on that edge; RD_EN while RD_VALID=0 SHALL be ignored.
REQ-022 A push into a full FIFO with no pop in the same cycle SHALL drop the byte and set OVERRUN; FIFO contents SHALL be unchanged.
REQ-023 A simultaneous push and pop on a full FIFO SHALL accept both, with no OVERRUN.
REQ-024 Simultaneous push and pop on an empty FIFO SHALL leave RD_VALID=1 holding the pushed byte.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit distinguishing full from empty.
REQ-026 CLR_ERR SHALL clear both sticky flags on the next edge; a same-cycle set event SHALL take priority over the clear.
REQ-027 UART_INT SHALL be registered as INT_EN & (RD_VALID | OVERRUN | FRAME_ERR), with one cycle of latency.

Reset
REQ-028 While RESET=0, the block SHALL be in IDLE with the FIFO empty and the synchronizer set to 1.
REQ-029 While RESET=0, outputs SHALL be RD_VALID=0, RD_DATA=0, OVERRUN=0, FRAME_ERR=0, UART_INT=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL wait for a fresh falling edge.

Configuration
REQ-031 With UART_RX_PARITY_EN defined, a PARITY state SHALL sit between DATA and STOP and check even parity.
REQ-032 With UART_RX_PARITY_EN defined, a parity mismatch SHALL discard the byte and set output PAR_ERR (1 bit, sticky, cleared by CLR_ERR, ORed into UART_INT).
REQ-033 With UART_RX_PARITY_EN undefined, the frame SHALL be 8N1, and neither PAR_ERR nor the PARITY state SHALL exist.

Structure
REQ-034 Package uart_pkg SHALL hold the FSM state enum, the default CLKS_PER_BIT constant, and the data-width constant (8).
REQ-035 The FIFO SHALL be sub-module uart_rx_fifo (parameter FIFO_DEPTH; push/pop/full/empty), instantiated once.

Verification (bench CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-036 Send 0xA5 8N1 -> RD_VALID=1 and RD_DATA=0xA5 one cycle after the stop sample; with INT_EN=1, UART_INT=1 the following cycle.
REQ-037 Send a 5-cycle low pulse on RXD -> the FSM returns to IDLE and RD_VALID, FRAME_ERR, OVERRUN all stay 0.
REQ-038 Send 0x3C with the stop bit forced low -> FRAME_ERR=1, FIFO empty; CLR_ERR pulse -> FRAME_ERR=0.
REQ-039 Send 5 bytes 0x01..0x05 with no reads -> OVERRUN=1 and pops return 0x01..0x04; 5 bytes with a pop timed on the 5th push -> no OVERRUN.
REQ-040 Assert RESET after data bit 3 of 0xFF, then send 0x12 -> only 0x12 is received.
REQ-041 With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> PAR_ERR=1, byte dropped; send 0x07 with parity bit 1 -> 0x07 received.
